// File: rtl/dff_response_checker.sv
// dff_response_checker: watches a D flip-flop (Q1/Q2) against a one-cycle
// reference model. It counts comparisons and failures with saturating
// counters and raises a sticky error flag on the first failure.
module dff_response_checker #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2   // ARM cycles before checking, 1..15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             DUT_RST_n,
  input  logic             Q1,
  input  logic             Q2,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             ERR,
  output logic [1:0]       STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

  localparam logic [3:0]       SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic             mv_q, mv_d;       // model has absorbed at least one edge
  logic             exp_q, exp_d;     // expected Q1 for the next edge
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  logic             err_q, err_d;
  logic             cmp_bad;

  // A Q1 miss and a Q2 miss in the same cycle collapse into one failure
  assign cmp_bad = (Q1 != exp_q) | (Q2 == Q1) | ~mv_q;

  // Next-state, reference model and counter update
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    mv_d     = mv_q;
    chk_d    = chk_q;
    errc_d   = errc_q;
    err_d    = err_q;
    // The model tracks the flop in every state, so it is warm when ARM ends
    exp_d    = DUT_RST_n & D;
    unique case (state_q)
      S_IDLE: begin
        mv_d = 1'b0;
        if (EN) begin
          state_d  = S_ARM;
          settle_d = SETTLE_M1;
        end
      end
      S_ARM: begin
        mv_d = 1'b1;
        if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
        if (!EN) state_d = S_IDLE;
        else if (settle_q == 4'd0) state_d = S_CHECK;
      end
      default: begin
        // CHECK and FAIL compare identically; FAIL only differs in being sticky
        if (!EN) begin
          state_d = S_IDLE;
        end else begin
          if (chk_q != CNT_MAX) chk_d = chk_q + CNT_ONE;
          if (cmp_bad) begin
            if (errc_q != CNT_MAX) errc_d = errc_q + CNT_ONE;
            err_d   = 1'b1;
            state_d = S_FAIL;
          end
        end
      end
    endcase
  end

  // State register; reset wins over any comparison on the same edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      settle_q <= 4'd0;
      mv_q     <= 1'b0;
      exp_q    <= 1'b0;
      chk_q    <= '0;
      errc_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      mv_q     <= mv_d;
      exp_q    <= exp_d;
      chk_q    <= chk_d;
      errc_q   <= errc_d;
      err_q    <= err_d;
    end
  end

  assign CHK_CNT = chk_q;
  assign ERR_CNT = errc_q;
  assign ERR     = err_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: directed scenarios plus a randomized run,
// both checked every cycle against a phase-based behavioural model.
module tb_dff_response_checker;

  localparam int SETTLE = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1, EN = 1'b0, D = 1'b0, DUT_RST_n = 1'b1;
  logic       Q1 = 1'b0, Q2 = 1'b1, Q1b = 1'b0, Q2b = 1'b1;
  logic [7:0] CHK_CNT, ERR_CNT;
  logic [3:0] CHK_CNT4, ERR_CNT4;
  logic       ERR, ERR4;
  logic [1:0] STATE, STATE4;

  dff_response_checker #(.CNT_W(8), .SETTLE(SETTLE)) u_dut (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .DUT_RST_n(DUT_RST_n),
    .Q1(Q1), .Q2(Q2), .CHK_CNT(CHK_CNT), .ERR_CNT(ERR_CNT),
    .ERR(ERR), .STATE(STATE));

  // Narrow-counter copy whose flop is always inverted, to exercise saturation
  dff_response_checker #(.CNT_W(4), .SETTLE(SETTLE)) u_dut4 (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .DUT_RST_n(DUT_RST_n),
    .Q1(Q1b), .Q2(Q2b), .CHK_CNT(CHK_CNT4), .ERR_CNT(ERR_CNT4),
    .ERR(ERR4), .STATE(STATE4));

  always #10 CLK = ~CLK;

  localparam int P_IDLE = 0, P_ARM = 1, P_CHECK = 2, P_FAIL = 3;

  typedef struct {
    int phase;
    int arm_edges;  // edges spent in ARM so far
    bit valid;
    bit expv;
    int chk;
    int errs;
    bit sticky;
  } mdl_t;

  mdl_t m8, m4;
  int   checks = 0, errors = 0;
  bit   dffv = 1'b0;     // state of the emulated flop under check
  int   mode_a = 0;      // 0 good,1 Q2=Q1,2 Q1 stuck1,3 Q1 inverted,4 random
  int   mode_b = 3;

  function automatic mdl_t step(mdl_t m, bit rst, bit en, bit d, bit rn,
                                bit q1, bit q2, int maxv);
    mdl_t n;
    n = m;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    n.expv = rn & d;
    if (m.phase == P_IDLE) begin
      n.valid = 0;
      if (en) begin n.phase = P_ARM; n.arm_edges = 0; end
    end else if (m.phase == P_ARM) begin
      n.valid = 1;
      n.arm_edges = m.arm_edges + 1;
      if (!en) n.phase = P_IDLE;
      else if (n.arm_edges == SETTLE) n.phase = P_CHECK;
    end else if (!en) begin
      n.phase = P_IDLE;
    end else begin
      n.chk = (m.chk < maxv) ? m.chk + 1 : maxv;
      if (q1 != m.expv || q2 == q1 || !m.valid) begin
        n.errs   = (m.errs < maxv) ? m.errs + 1 : maxv;
        n.sticky = 1;
        n.phase  = P_FAIL;
      end
    end
    return n;
  endfunction

  task automatic drive(input int mode, input bit f, output logic q1, output logic q2);
    case (mode)
      1:       begin q1 = f;  q2 = f;  end
      2:       begin q1 = 1;  q2 = 0;  end
      3:       begin q1 = ~f; q2 = f;  end
      4:       begin q1 = 1'($urandom); q2 = 1'($urandom); end
      default: begin q1 = f;  q2 = ~f; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied after the falling edge, outputs sampled 1 after rise
  task automatic tick(input bit rst, input bit en, input bit d, input bit rn);
    logic a1, a2, b1, b2;
    RST = rst; EN = en; D = d; DUT_RST_n = rn;
    drive(mode_a, dffv, a1, a2);
    drive(mode_b, dffv, b1, b2);
    Q1 = a1; Q2 = a2; Q1b = b1; Q2b = b2;
    m8 = step(m8, rst, en, d, rn, a1, a2, 255);
    m4 = step(m4, rst, en, d, rn, b1, b2, 15);
    @(posedge CLK);
    #1;
    dffv = rn & d;
    chk("m8.state", 32'(STATE),   m8.phase);
    chk("m8.chk",   32'(CHK_CNT), m8.chk);
    chk("m8.errs",  32'(ERR_CNT), m8.errs);
    chk("m8.err",   32'(ERR),     32'(m8.sticky));
    chk("m4.state", 32'(STATE4),  m4.phase);
    chk("m4.chk",   32'(CHK_CNT4), m4.chk);
    chk("m4.errs",  32'(ERR_CNT4), m4.errs);
    chk("m4.err",   32'(ERR4),    32'(m4.sticky));
    @(negedge CLK);
  endtask

  initial begin
    int c0;
    m8 = '{default: 0};
    m4 = '{default: 0};

    // Reset state
    tick(1, 1, 0, 1);
    chk("rst.state", 32'(STATE), 0);
    chk("rst.chk",   32'(CHK_CNT), 0);
    chk("rst.err",   32'(ERR), 0);

    // Correct flop, D toggles every 2 cycles, DUT_RST_n every 4, 200 cycles
    mode_a = 0;
    for (int i = 0; i < 200; i++) begin
      tick(0, 1, 1'((i >> 1) & 1), 1'(~(i >> 2) & 1));
      if (i == 39) begin
        chk("sat4.chk",  32'(CHK_CNT4), 15);
        chk("sat4.errs", 32'(ERR_CNT4), 15);
      end
    end
    chk("good.err",   32'(ERR), 0);
    chk("good.errs",  32'(ERR_CNT), 0);
    chk("good.chk",   32'(CHK_CNT), 200 - SETTLE - 1);
    chk("good.state", 32'(STATE), P_CHECK);

    // EN gap of 3 cycles mid-CHECK, then re-arm
    c0 = int'(CHK_CNT);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1'($urandom), 1);
      chk("gap.state", 32'(STATE), P_IDLE);
      chk("gap.chk",   32'(CHK_CNT), c0);
    end
    for (int i = 0; i < SETTLE; i++) begin
      tick(0, 1, 1'($urandom), 1);
      chk("rearm.state", 32'(STATE), P_ARM);
      chk("rearm.chk",   32'(CHK_CNT), c0);
    end
    tick(0, 1, 1'($urandom), 1);
    chk("rearm.enter", 32'(STATE), P_CHECK);
    chk("rearm.hold",  32'(CHK_CNT), c0);
    tick(0, 1, 1'($urandom), 1);
    chk("rearm.count", 32'(CHK_CNT), c0 + 1);

    // Q2 tied to Q1: fails on first CHECK edge, every comparison an error
    tick(1, 0, 0, 1);
    mode_a = 1;
    for (int i = 1; i <= SETTLE + 1; i++) tick(0, 1, 1'($urandom), 1'($urandom));
    chk("q2tie.state0", 32'(STATE), P_CHECK);
    for (int k = 1; k <= 5; k++) begin
      tick(0, 1, 1'($urandom), 1'($urandom));
      chk("q2tie.state", 32'(STATE), P_FAIL);
      chk("q2tie.err",   32'(ERR), 1);
      chk("q2tie.chk",   32'(CHK_CNT), k);
      chk("q2tie.errs",  32'(ERR_CNT), k);
    end

    // Reset while in FAIL with ERR_CNT=5 clears everything on that edge
    tick(1, 1, 0, 1);
    chk("rstfail.chk",   32'(CHK_CNT), 0);
    chk("rstfail.errs",  32'(ERR_CNT), 0);
    chk("rstfail.err",   32'(ERR), 0);
    chk("rstfail.state", 32'(STATE), P_IDLE);

    // Q1 stuck at 1, D=1, one-cycle DUT reset pulse at cycle 20
    mode_a = 2;
    for (int i = 1; i <= 40; i++) begin
      tick(0, 1, 1, (i == 20) ? 1'b0 : 1'b1);
      if (i == 20) chk("stuck.before", 32'(ERR), 0);
      if (i == 21) chk("stuck.at",     32'(ERR), 1);
    end
    chk("stuck.errs", 32'(ERR_CNT), 1);

    // Randomized traffic with occasional faults, EN drops and resets
    for (int i = 0; i < 400; i++) begin
      mode_a = $urandom_range(0, 9);
      if (mode_a > 4) mode_a = 0;
      tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
           1'($urandom), ($urandom_range(0, 7) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_response_checker.md
DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

Interface
REQ-001 Parameter CNT_W, default 8, width of the check and error counters.
REQ-002 Parameter SETTLE, default 2, number of CLK cycles spent in ARM before comparisons start; legal range 1..15.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  checking enable; level-sensitive.
REQ-006 D  input  1  data value presented to the D flip-flop under check.
REQ-007 DUT_RST_n  input  1  active-low synchronous reset presented to the D flip-flop under check.
REQ-008 Q1  input  1  true output of the D flip-flop under check.
REQ-009 Q2  input  1  complement output of the D flip-flop under check.
REQ-010 CHK_CNT  output  CNT_W  number of comparisons performed.
REQ-011 ERR_CNT  output  CNT_W  number of failed comparisons.
REQ-012 ERR  output  1  sticky flag, set on the first failed comparison.
REQ-013 STATE  output  2  current state: IDLE=0, ARM=1, CHECK=2, FAIL=3.

Function
REQ-014 Reference model: on every CLK edge with RST=0, register EXP is loaded as follows: 0 if DUT_RST_n=0, otherwise D. This update happens in every state.
REQ-015 A comparison at edge k checks three conditions: Q1 == EXP, where EXP is the value loaded at edge k-1, Q2 == ~Q1, and the registered model-valid bit is 1.
REQ-016 Model-valid bit: cleared in IDLE; set at the first edge in ARM.
REQ-017 IDLE: with EN=1, the next state is ARM and the settle counter loads SETTLE-1; with EN=0, the state stays IDLE.
REQ-018 ARM: the settle counter decrements each edge; when it reaches 0 with EN=1, the next state is CHECK. No comparisons are made in ARM.
REQ-019 CHECK: one comparison is made per edge and CHK_CNT increments. On a failed comparison, ERR_CNT increments, ERR is set, and the next state is FAIL.
REQ-020 FAIL: comparisons and counting continue exactly as in CHECK. The state stays FAIL until reset or until EN=0.
REQ-021 EN=0 in ARM, CHECK or FAIL: the next state is IDLE. No comparison is made on that edge. The counters and ERR hold their values.
REQ-022 Re-entering ARM from IDLE does not clear CHK_CNT, ERR_CNT or ERR; only RST clears them.
REQ-023 Counters saturate at 2^CNT_W-1 and never wrap. Once CHK_CNT saturates, ERR_CNT still increments (saturating).
REQ-024 Q2 mismatch with a correct Q1 is counted as one error. A mismatch on both Q1 and Q2 in the same cycle is also counted as one error.
REQ-025 A DUT_RST_n transition in CHECK needs no special handling: the model absorbs it through REQ-014, and the comparison one edge later expects Q1=0.
REQ-026 Outputs are registered. CHK_CNT, ERR_CNT, ERR and STATE change only on CLK edges.

Reset
REQ-027 At an edge where RST=1, the block sets: STATE=IDLE, EXP=0, model-valid=0, settle counter=0, CHK_CNT=0, ERR_CNT=0, ERR=0.
REQ-028 RST takes priority over EN and over any comparison pending on the same edge. That comparison is discarded and not counted.
REQ-029 Asserting RST mid-CHECK or mid-FAIL returns the block to IDLE on that edge. Checking resumes only after RST=0 and EN=1.

Verification
REQ-030 Scenario: correct DFF model, CLK period 20, D toggling every 40, DUT_RST_n toggling every 80, EN=1 from t=0, 200 cycles. Required: ERR=0, ERR_CNT=0, CHK_CNT=200-SETTLE-1, STATE=CHECK.
REQ-031 Scenario: Q2 tied equal to Q1. Required: ERR=1 and STATE=FAIL on the first CHECK edge; ERR_CNT equals CHK_CNT thereafter.
REQ-032 Scenario: Q1 stuck at 1, D=1 held, DUT_RST_n pulsed low for one cycle at cycle 20. Required: exactly one error, detected one edge after the pulse; ERR_CNT=1.
REQ-033 Scenario: CNT_W=4, Q1 inverted permanently, 40 cycles. Required: ERR_CNT=15 and CHK_CNT=15, with no wrap.
REQ-034 Scenario: EN dropped for 3 cycles mid-CHECK, then restored. Required: STATE goes IDLE then ARM for SETTLE cycles then CHECK; CHK_CNT holds during the gap and ARM.
REQ-035 Scenario: RST=1 for one cycle while in FAIL with ERR_CNT=5. Required: the next-edge outputs are CHK_CNT=0, ERR_CNT=0, ERR=0, STATE=IDLE.
